// File: rtl/fetch_pkg.sv
// Shared widths, constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W      = 32;
  localparam int INSTR_W   = 32;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A new fetch may issue only if every word already owed to the buffer
  // (buffered plus in flight, minus the one leaving this cycle) leaves a
  // free slot for the response that will arrive next cycle.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [OCC_W:0] used;
    used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    return used <= (OCC_W + 1)'(BUF_DEPTH - 1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry shift FIFO of {pc, instr} between the memory response and decode.
// The head lives in a fixed register so the outputs are straight register
// outputs and simply hold their last value once the buffer drains.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [OCC_W-1:0]   occ,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  fetch_entry_t     head_q;
  fetch_entry_t     tail_q;
  fetch_entry_t     push_entry;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_after_pop;
  logic [OCC_W-1:0] occ_d;
  logic             pop_ok;
  logic             push_ok;

  // Occupancy bookkeeping: a pop frees its slot before the push lands.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    push_entry    = '{pc: push_pc, instr: push_instr};
    pop_ok        = pop && (occ_q != '0);
    occ_after_pop = occ_q - {{(OCC_W-1){1'b0}}, pop_ok};
    push_ok       = push && (occ_after_pop < OCC_W'(BUF_DEPTH));
    occ_d         = occ_after_pop + {{(OCC_W-1){1'b0}}, push_ok};
  end

  // Storage update: shift tail into head on pop, write the push into the
  // first free slot; flush only empties, leaving the head contents visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is reset here because the idle head values are visible on the outputs.
      occ_q  <= '0;
      head_q <= '{pc: '0, instr: NOP_INSTR};
      tail_q <= '{pc: '0, instr: NOP_INSTR};
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so head_q <= tail_q reads the old tail.
      occ_q <= occ_d;
      if (pop_ok && (occ_q == OCC_W'(BUF_DEPTH))) begin
        head_q <= tail_q;
      end
      if (push_ok) begin
        if (occ_after_pop == '0) begin
          head_q <= push_entry;
        end else begin
          tail_q <= push_entry;
        end
      end
    end
  end

  assign occ        = occ_q;
  assign head_pc    = head_q.pc;
  assign head_instr = head_q.instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word-addressed reads to
// Memoria, tracks the single outstanding read, and hands instructions to
// decode through the skid buffer. Redirects flush everything in flight.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ReadPC,
  output logic        mem_req,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_next
);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  inflight_pc_q;
  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             issue;

  // Handshake and issue decision; reset and redirect both block issue.
  always_comb begin
    pop   = id_valid && id_ready;
    issue = !reset && !redirect_valid && credit_ok(occ, inflight_q, pop);
  end

  // PC and outstanding-read tracking; reset beats redirect beats issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + PC_STEP;
      end
    end
  end

  // The response to last cycle's issue is pushed now; a redirect flushes it.
  fetch_skid_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .push_pc    (inflight_pc_q),
    .push_instr (Instruction),
    .pop        (pop),
    .flush      (redirect_valid),
    .occ        (occ),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

  assign ReadPC     = pc_q;
  assign mem_req    = issue;
  assign id_valid   = (occ != '0);
  assign id_pc_next = id_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// ready/redirect/reset traffic, compared cycle by cycle with a queue model.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] ReadPC;
  logic        mem_req;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;

  int errors = 0;
  int checks = 0;

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_disp_pc;
  logic [31:0] m_disp_instr;

  // values sampled in the most recent cycle, for directed checks
  logic [31:0] s_readpc, s_id_instr, s_id_pc, s_id_pc_next;
  logic        s_mem_req, s_id_valid;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ReadPC         (ReadPC),
    .mem_req        (mem_req),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_next     (id_pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16)       return (a + 32'd1) * 32'h11;
    else if (a == 32'h40) return 32'hAA;
    else                  return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memoria: 1-cycle registered read of whatever address is presented.
  always @(posedge clk) Instruction <= mem_word(ReadPC);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc          = 32'h0;
    m_inflight    = 1'b0;
    m_inflight_pc = 32'h0;
    m_disp_pc     = 32'h0;
    m_disp_instr  = 32'h0;
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic exp_valid, pop, issue;
    int   used;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(negedge clk);
    exp_valid = (mq.size() != 0);
    pop       = exp_valid && rdy;
    used      = mq.size() + (m_inflight ? 1 : 0) - (pop ? 1 : 0);
    issue     = !rst && !rv && (used <= 1);

    check("readpc",     ReadPC,             m_pc);
    check("mem_req",    {31'b0, mem_req},   {31'b0, issue});
    check("id_valid",   {31'b0, id_valid},  {31'b0, exp_valid});
    check("id_pc",      id_pc,              m_disp_pc);
    check("id_instr",   id_instr,           m_disp_instr);
    check("id_pc_next", id_pc_next,         m_disp_pc + 32'd1);

    s_readpc = ReadPC;  s_mem_req = mem_req;   s_id_valid = id_valid;
    s_id_pc  = id_pc;   s_id_instr = id_instr; s_id_pc_next = id_pc_next;

    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        m_inflight = 1'b0;
        m_pc       = rpc;
      end else begin
        if (m_inflight) mq.push_back('{pc: m_inflight_pc, instr: mem_word(m_inflight_pc)});
        m_inflight = issue;
        if (issue) begin
          m_inflight_pc = m_pc;
          m_pc          = m_pc + 32'd1;
        end
      end
      if (mq.size() != 0) begin
        m_disp_pc    = mq[0].pc;
        m_disp_instr = mq[0].instr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    cycle(1, 0, 0, 1);
    check("rst_valid",   {31'b0, s_id_valid}, 32'd0);
    check("rst_pc_next", s_id_pc_next,        32'd1);
    check("rst_mem_req", {31'b0, s_mem_req},  32'd0);

    // startup, cycles 0..2
    cycle(0, 0, 0, 1);
    check("start_rpc0", s_readpc, 32'h0);
    check("start_req0", {31'b0, s_mem_req}, 32'd1);
    cycle(0, 0, 0, 1);
    check("start_rpc1", s_readpc, 32'h1);
    cycle(0, 0, 0, 1);
    check("start_valid", {31'b0, s_id_valid}, 32'd1);
    check("start_instr", s_id_instr, 32'h11);

    // backpressure, cycles 3..7
    for (int c = 3; c <= 7; c++) begin
      cycle(0, 0, 0, 0);
      check("bp_hold", s_id_instr, 32'h22);
    end
    check("bp_no_req", {31'b0, s_mem_req}, 32'd0);
    cycle(0, 0, 0, 1);
    check("bp_rel0", s_id_instr, 32'h22);
    cycle(0, 0, 0, 1);
    check("bp_rel1", s_id_instr, 32'h33);
    cycle(0, 0, 0, 1);
    check("bp_rel2", s_id_instr, 32'h44);

    // redirect together with a pop; in-flight PC 5 must be dropped
    cycle(0, 1, 32'h40, 1);
    check("rd_pop_pc", s_id_pc, 32'h4);
    cycle(0, 0, 0, 1);
    check("rd_gap_valid", {31'b0, s_id_valid}, 32'd0);
    check("rd_issue_pc",  s_readpc, 32'h40);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("rd_tgt_pc",    s_id_pc,    32'h40);
    check("rd_tgt_instr", s_id_instr, 32'hAA);

    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFF, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("wrap_pc0",   s_id_pc,      32'hFFFF_FFFF);
    check("wrap_next0", s_id_pc_next, 32'h0);
    cycle(0, 0, 0, 1);
    check("wrap_pc1",   s_id_pc,      32'h0);

    // reset mid-stream with a full buffer
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("mrst_valid", {31'b0, s_id_valid}, 32'd0);
    cycle(0, 0, 0, 1);
    check("mrst_rpc", s_readpc, 32'h0);
    check("mrst_req", {31'b0, s_mem_req}, 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = $urandom_range(0, 100);
        1:       rpc = 32'hFFFF_FFFF - $urandom_range(0, 3);
        2:       rpc = $urandom;
        default: rpc = 32'h40;
      endcase
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 19) == 0),
            rpc,
            ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
